// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, default frame
// marker and instruction memory depth (must match the cpu's 8-bit rom_address).
package program_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StChk,
    StRun,
    StError
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned ROM_WORDS         = 256;

endpackage

// File: rtl/program_loader_if.sv
// Bus between the program loader and its neighbours.
//   uart_rx      : serial input, idle high, asynchronous to clk
//   rom_address  : cpu fetch word address
//   rom_data     : instruction word at rom_address (combinational)
//   cpu_enable   : 1 = cpu may clock
//   cpu_reset    : 1 = cpu held in reset
//   load_error   : sticky, set by a failed frame
//   words_loaded : word count of the last good frame
// The slave modport is the loader; master is the cpu/host side.
interface program_loader_if;
  logic        uart_rx;
  logic [7:0]  rom_address;
  logic [31:0] rom_data;
  logic        cpu_enable;
  logic        cpu_reset;
  logic        load_error;
  logic [8:0]  words_loaded;

  modport slave (
    input  uart_rx,
    input  rom_address,
    output rom_data,
    output cpu_enable,
    output cpu_reset,
    output load_error,
    output words_loaded
  );

  modport master (
    output uart_rx,
    output rom_address,
    input  rom_data,
    input  cpu_enable,
    input  cpu_reset,
    input  load_error,
    input  words_loaded
  );
endinterface

// File: rtl/program_loader_uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk, rst       : system clock, asynchronous active-high reset
//   rx_i           : raw serial input (synchronised internally)
//   byte_data_o    : last received byte
//   byte_valid_o   : 1-clk pulse, byte_data_o holds a byte with a good stop bit
//   frame_err_o    : 1-clk pulse, stop bit sampled low (no byte emitted)
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_data_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned    CntW     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  rx_state_e       state_q;
  logic [1:0]      sync_q;
  logic            rx_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            valid_q;
  logic            ferr_q;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RxIdle;
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          // Edge-triggered so a stuck-low line after a bad stop bit cannot retrigger.
          if (rx_prev_q && !rx_s) begin
            state_q <= RxStart;
            cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            // Line back high at mid start bit: glitch, not a start.
            state_q <= rx_s ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RxStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            state_q <= RxIdle;
            if (rx_s) valid_q <= 1'b1;
            else      ferr_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign byte_data_o  = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/program_loader.sv
// Program loader: owns the 256x32 cpu instruction memory, fills it from a
// UART frame (SYNC, LEN, 4*(LEN+1) little-endian data bytes, XOR checksum)
// and holds the cpu in reset until a checksum-verified load completes.
//   clk, rst : system clock, asynchronous active-high reset
//   bus_io   : uart_rx / rom_address in; rom_data, cpu_enable, cpu_reset,
//              load_error, words_loaded out
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned TIMEOUT_CLKS = 2700000,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  program_loader_if.slave        bus_io
);

  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CLKS - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (bus_io.uart_rx),
    .byte_data_o  (rx_data),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );

  state_e          state_q;
  logic [7:0]      len_q;
  logic [7:0]      addr_q;
  logic [1:0]      byte_idx_q;
  logic [7:0]      chk_q;
  logic [23:0]     word_q;    // first three bytes of the word being assembled
  logic [TmoW-1:0] tmo_q;
  logic            cpu_enable_q;
  logic            cpu_reset_q;
  logic            load_error_q;
  logic [8:0]      words_loaded_q;

  logic        in_frame;
  logic        tmo_hit;
  logic        wr_en;
  logic [31:0] wr_data;

  logic [31:0] mem [ROM_WORDS];

  assign in_frame = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
  assign tmo_hit  = in_frame && !rx_valid && (tmo_q == TmoLast);
  assign wr_en    = (state_q == StData) && rx_valid && (byte_idx_q == 2'd3);
  assign wr_data  = {rx_data, word_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      len_q          <= '0;
      addr_q         <= '0;
      byte_idx_q     <= '0;
      chk_q          <= '0;
      word_q         <= '0;
      tmo_q          <= '0;
      cpu_enable_q   <= 1'b0;
      cpu_reset_q    <= 1'b1;
      load_error_q   <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      if (rx_valid || !in_frame) tmo_q <= '0;
      else                       tmo_q <= tmo_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (rx_valid && rx_data == SYNC_BYTE) state_q <= StLen;
        end
        StLen: begin
          if (rx_valid) begin
            len_q      <= rx_data;
            addr_q     <= '0;
            byte_idx_q <= '0;
            chk_q      <= rx_data;  // LEN is part of the checksum
            state_q    <= StData;
          end
        end
        StData: begin
          if (rx_valid) begin
            chk_q      <= chk_q ^ rx_data;
            byte_idx_q <= byte_idx_q + 1'b1;
            unique case (byte_idx_q)
              2'd0: word_q[7:0]   <= rx_data;
              2'd1: word_q[15:8]  <= rx_data;
              2'd2: word_q[23:16] <= rx_data;
              2'd3: begin
                addr_q <= addr_q + 1'b1;
                if (addr_q == len_q) state_q <= StChk;
              end
              default: ;
            endcase
          end
        end
        StChk: begin
          if (rx_valid) begin
            if (rx_data == chk_q) begin
              state_q        <= StRun;
              words_loaded_q <= {1'b0, len_q} + 9'd1;
              load_error_q   <= 1'b0;
              cpu_reset_q    <= 1'b0;
              cpu_enable_q   <= 1'b1;
            end else begin
              state_q      <= StError;
              load_error_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_q      <= StLen;
            cpu_enable_q <= 1'b0;
            cpu_reset_q  <= 1'b1;
          end
        end
        StError: begin
          if (rx_valid && rx_data == SYNC_BYTE) state_q <= StLen;
        end
        default: state_q <= StIdle;
      endcase

      // Line errors and stalls abort any frame in progress.
      if (in_frame && (rx_ferr || tmo_hit)) begin
        state_q      <= StError;
        load_error_q <= 1'b1;
      end
    end
  end

  // Memory is deliberately not reset; partial loads keep the words they wrote.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q] <= wr_data;
  end

  assign bus_io.rom_data     = mem[bus_io.rom_address];
  assign bus_io.cpu_enable   = cpu_enable_q;
  assign bus_io.cpu_reset    = cpu_reset_q;
  assign bus_io.load_error   = load_error_q;
  assign bus_io.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (CLKS_PER_BIT=4, TIMEOUT_CLKS=200).
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int unsigned CPB = 4;
  localparam int unsigned TMO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;
  int   bv_cnt = 0;
  int   fe_cnt = 0;

  program_loader_if bus ();

  program_loader #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.rx_valid) bv_cnt++;
    if (dut.rx_ferr)  fe_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    bus.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_frame0(input logic [7:0] chk);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h50, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(chk, 1'b1);
  endtask

  task automatic test_reset;
    bus.uart_rx = 1'b1;
    bus.rom_address = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.cpu_enable !== 1'b0) begin
      $display("FAIL reset_cpu_enable: got %b want 0", bus.cpu_enable); failed++; end
    tests++; if (bus.cpu_reset !== 1'b1) begin
      $display("FAIL reset_cpu_reset: got %b want 1", bus.cpu_reset); failed++; end
    tests++; if (bus.load_error !== 1'b0) begin
      $display("FAIL reset_load_error: got %b want 0", bus.load_error); failed++; end
    tests++; if (bus.words_loaded !== 9'd0) begin
      $display("FAIL reset_words_loaded: got %0d want 0", bus.words_loaded); failed++; end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame;
    send_frame0(8'h43);
    bus.rom_address = 8'd0;
    #1;
    tests++; if (bus.cpu_reset !== 1'b0) begin
      $display("FAIL good_cpu_reset: got %b want 0", bus.cpu_reset); failed++; end
    tests++; if (bus.cpu_enable !== 1'b1) begin
      $display("FAIL good_cpu_enable: got %b want 1", bus.cpu_enable); failed++; end
    tests++; if (bus.words_loaded !== 9'd1) begin
      $display("FAIL good_words_loaded: got %0d want 1", bus.words_loaded); failed++; end
    tests++; if (bus.rom_data !== 32'h00500013) begin
      $display("FAIL good_rom_data: got %h want 00500013", bus.rom_data); failed++; end
  endtask

  task automatic test_bad_chk;
    send_frame0(8'h44);
    tests++; if (bus.cpu_enable !== 1'b0) begin
      $display("FAIL badchk_cpu_enable: got %b want 0", bus.cpu_enable); failed++; end
    tests++; if (bus.load_error !== 1'b1) begin
      $display("FAIL badchk_load_error: got %b want 1", bus.load_error); failed++; end
    send_frame0(8'h43);
    tests++; if (bus.load_error !== 1'b0) begin
      $display("FAIL recover_load_error: got %b want 0", bus.load_error); failed++; end
    tests++; if (bus.cpu_enable !== 1'b1) begin
      $display("FAIL recover_cpu_enable: got %b want 1", bus.cpu_enable); failed++; end
  endtask

  task automatic test_reload;
    int n;
    n = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (!dut.rx_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        tests++;
        if (n >= 200) begin
          $display("FAIL reload_wait: got no byte_valid within 200 clks, want one"); failed++;
        end else begin
          if (bus.cpu_enable !== 1'b1) begin
            $display("FAIL reload_pre_enable: got %b want 1", bus.cpu_enable); failed++; end
          @(negedge clk);
          tests++; if (bus.cpu_enable !== 1'b0) begin
            $display("FAIL reload_enable_fall: got %b want 0", bus.cpu_enable); failed++; end
          tests++; if (bus.cpu_reset !== 1'b1) begin
            $display("FAIL reload_reset_rise: got %b want 1", bus.cpu_reset); failed++; end
        end
      end
    join
    // LEN=1, words 0x11223344 and 0xDEADBEEF, CHK = 0x01 ^ all data bytes = 0x67
    send_byte(8'h01, 1'b1);
    send_byte(8'h44, 1'b1); send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b1); send_byte(8'h11, 1'b1);
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
    send_byte(8'h67, 1'b1);
    tests++; if (bus.words_loaded !== 9'd2) begin
      $display("FAIL reload_words_loaded: got %0d want 2", bus.words_loaded); failed++; end
    tests++; if (bus.cpu_enable !== 1'b1) begin
      $display("FAIL reload_cpu_enable: got %b want 1", bus.cpu_enable); failed++; end
    bus.rom_address = 8'd0; #1;
    tests++; if (bus.rom_data !== 32'h11223344) begin
      $display("FAIL reload_mem0: got %h want 11223344", bus.rom_data); failed++; end
    bus.rom_address = 8'd1; #1;
    tests++; if (bus.rom_data !== 32'hDEADBEEF) begin
      $display("FAIL reload_mem1: got %h want deadbeef", bus.rom_data); failed++; end
  endtask

  task automatic test_timeout;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    send_byte(8'h99, 1'b1);
    repeat (300) @(negedge clk);
    tests++; if (bus.load_error !== 1'b1) begin
      $display("FAIL tmo_load_error: got %b want 1", bus.load_error); failed++; end
    tests++; if (bus.cpu_enable !== 1'b0 || bus.cpu_reset !== 1'b1) begin
      $display("FAIL tmo_cpu_held: got en=%b rst=%b want en=0 rst=1",
               bus.cpu_enable, bus.cpu_reset); failed++; end
    tests++; if (bus.words_loaded !== 9'd2) begin
      $display("FAIL tmo_words_loaded: got %0d want 2", bus.words_loaded); failed++; end
    bus.rom_address = 8'd0; #1;
    tests++; if (bus.rom_data !== 32'h12345678) begin
      $display("FAIL tmo_mem0: got %h want 12345678", bus.rom_data); failed++; end
    bus.rom_address = 8'd1; #1;
    tests++; if (bus.rom_data !== 32'hDEADBEEF) begin
      $display("FAIL tmo_mem1: got %h want deadbeef", bus.rom_data); failed++; end
  endtask

  task automatic test_glitch_and_stop;
    int bv0;
    int fe0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    bus.uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (bv_cnt !== bv0 || fe_cnt !== fe0) begin
      $display("FAIL glitch_no_byte: got %0d bytes %0d errs want 0 0",
               bv_cnt - bv0, fe_cnt - fe0); failed++; end
    tests++; if (dut.state_q !== StIdle) begin
      $display("FAIL glitch_state: got %0d want %0d", dut.state_q, StIdle); failed++; end
    tests++; if (bus.load_error !== 1'b0) begin
      $display("FAIL glitch_load_error: got %b want 0", bus.load_error); failed++; end
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    fe0 = fe_cnt;
    send_byte(8'h50, 1'b0);
    tests++; if (fe_cnt !== fe0 + 1) begin
      $display("FAIL stop0_frame_err: got %0d want %0d", fe_cnt, fe0 + 1); failed++; end
    tests++; if (bus.load_error !== 1'b1) begin
      $display("FAIL stop0_load_error: got %b want 1", bus.load_error); failed++; end
    tests++; if (dut.state_q !== StError) begin
      $display("FAIL stop0_state: got %0d want %0d", dut.state_q, StError); failed++; end
  endtask

  task automatic test_reset_mid_load;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    tests++; if (dut.state_q !== StIdle) begin
      $display("FAIL midrst_state: got %0d want %0d", dut.state_q, StIdle); failed++; end
    tests++; if (bus.cpu_reset !== 1'b1 || bus.cpu_enable !== 1'b0) begin
      $display("FAIL midrst_cpu_held: got rst=%b en=%b want rst=1 en=0",
               bus.cpu_reset, bus.cpu_enable); failed++; end
    tests++; if (bus.load_error !== 1'b0) begin
      $display("FAIL midrst_load_error: got %b want 0", bus.load_error); failed++; end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame0(8'h43);
    bus.rom_address = 8'd0; #1;
    tests++; if (bus.words_loaded !== 9'd1) begin
      $display("FAIL midrst_words_loaded: got %0d want 1", bus.words_loaded); failed++; end
    tests++; if (bus.cpu_enable !== 1'b1 || bus.cpu_reset !== 1'b0) begin
      $display("FAIL midrst_run: got en=%b rst=%b want en=1 rst=0",
               bus.cpu_enable, bus.cpu_reset); failed++; end
    tests++; if (bus.rom_data !== 32'h00500013) begin
      $display("FAIL midrst_mem0: got %h want 00500013", bus.rom_data); failed++; end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_reload();
    test_timeout();
    test_glitch_and_stop();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
